// File: rtl/sprite_engine.sv
// sprite_engine
// -----------------------------------------------------------------------------
// Moves a square sprite across the VGA playfield under joystick control and
// renders it pixel by pixel for the layer mixer.
//
// The latched nunchuk stick is turned into a signed per-axis velocity. That
// velocity is integrated into a working position once per motion tick, with
// wrap or clamp handling at the playfield edges. The working position is
// copied to pos_x/pos_y only at frame start, so a frame never shows a torn
// sprite. For each scanned pixel the block issues a bitmap ROM address and
// returns the palette index and an opacity flag two clocks later.
//
// Optional feature macro: SPRITE_MIRROR_EN
//   When it is defined, the block tracks the horizontal direction of travel
//   and mirrors the bitmap columns so the sprite faces the way it moves.
//
// Ports:
//   clock          pixel clock
//   reset          synchronous, active-high
//   display_col    current scan column (12 bits)
//   display_row    current scan row (11 bits)
//   joy_x, joy_y   raw nunchuk stick axes, 0x80 is centre
//   joy_valid      one-cycle strobe qualifying joy_x/joy_y
//   edge_mode      0 = wrap, 1 = clamp; sampled on each motion tick
//   rom_addr       {row texel, column texel} to the bitmap ROM
//   rom_data       palette index from the ROM, one clock after rom_addr
//   pos_x, pos_y   committed sprite left/top edge
//   pixel_index    palette index of the pixel scanned two clocks earlier
//   pixel_opaque   pixel is inside the sprite and not the transparent index
// -----------------------------------------------------------------------------
module sprite_engine #(
  parameter int HOR_FIELD   = 799,
  parameter int VER_FIELD   = 599,
  parameter int SIZE_LOG2   = 6,
  parameter int SCALE_LOG2  = 2,
  parameter int TICK_BITS   = 20,
  parameter int DEADZONE    = 1,
  parameter int START_X     = 368,
  parameter int START_Y     = 268,
  parameter int TRANSPARENT = 0,
  localparam int ROM_AW     = 2 * (SIZE_LOG2 - SCALE_LOG2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       display_col,
  input  logic [10:0]       display_row,
  input  logic [7:0]        joy_x,
  input  logic [7:0]        joy_y,
  input  logic              joy_valid,
  input  logic              edge_mode,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [11:0]       pos_x,
  output logic [10:0]       pos_y,
  output logic [3:0]        pixel_index,
  output logic              pixel_opaque
);

  localparam int SIZE     = 1 << SIZE_LOG2;
  localparam int TEX_BITS = SIZE_LOG2 - SCALE_LOG2;

  localparam logic signed [12:0] SIZE_S = 13'(SIZE);
  localparam logic signed [12:0] HOR_S  = 13'(HOR_FIELD);
  localparam logic signed [12:0] VER_S  = 13'(VER_FIELD);
  localparam logic signed [12:0] DZ_S   = 13'(DEADZONE);

  logic [7:0]           latch_x;
  logic [7:0]           latch_y;
  logic [TICK_BITS-1:0] tick_count;
  logic                 tick;
  logic signed [12:0]   raw_vx;
  logic signed [12:0]   raw_vy;
  logic signed [12:0]   vel_x;
  logic signed [12:0]   vel_y;
  logic signed [12:0]   work_x;
  logic signed [12:0]   work_y;
  logic                 frame_start;
  logic                 mirror;
  logic                 in_x;
  logic                 in_y;
  logic                 hit;
  logic [TEX_BITS-1:0]  tex_x;
  logic [TEX_BITS-1:0]  tex_y;
  logic [ROM_AW-1:0]    addr_next;
  logic                 hit_s0;
  logic                 hit_s1;

  // One motion step on a single axis. The arithmetic is signed 13-bit, so a
  // step past the left/top edge goes negative rather than wrapping unsigned.
  function automatic logic signed [12:0] next_pos(
    input logic signed [12:0] w,
    input logic signed [12:0] v,
    input logic signed [12:0] field,
    input logic               clamp
  );
    logic signed [12:0] n;
    n = w + v;
    if (clamp) begin
      if (n < 13'sd1) n = 13'sd1;
      else if (n > field - SIZE_S) n = field - SIZE_S;
    end else begin
      if (n < 13'sd1) n = field - SIZE_S - 13'sd1;
      else if (n + SIZE_S > field) n = 13'sd1;
    end
    return n;
  endfunction

  // Joystick sample latch. It is read by the motion tick, so a sample that
  // arrives in the same cycle as a tick only counts from the next tick on.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_x <= 8'h80;
      latch_y <= 8'h80;
    end else if (joy_valid) begin
      latch_x <= joy_x;
      latch_y <= joy_y;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tick_count <= '0;
    else       tick_count <= tick_count + TICK_BITS'(1);
  end

  assign tick = &tick_count;

  // Only the top nibble of each axis drives the speed. The y axis is negated
  // so pushing the stick up moves the sprite up the screen.
  always_comb begin
    raw_vx = $signed({9'b0, latch_x[7:4]}) - 13'sd8;
    raw_vy = 13'sd8 - $signed({9'b0, latch_y[7:4]});
    vel_x  = raw_vx;
    vel_y  = raw_vy;
    if (raw_vx <= DZ_S && raw_vx >= -DZ_S) vel_x = 13'sd0;
    if (raw_vy <= DZ_S && raw_vy >= -DZ_S) vel_y = 13'sd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      work_x <= 13'(START_X);
      work_y <= 13'(START_Y);
    end else if (tick) begin
      work_x <= next_pos(work_x, vel_x, HOR_S, edge_mode);
      work_y <= next_pos(work_y, vel_y, VER_S, edge_mode);
    end
  end

  assign frame_start = (display_col == 12'd0) && (display_row == 11'd0);

  // The commit reads the working position as it was before any coincident
  // tick, so that tick's step shows up one frame later.
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x <= 12'(START_X);
      pos_y <= 11'(START_Y);
    end else if (frame_start) begin
      pos_x <= work_x[11:0];
      pos_y <= work_y[10:0];
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic facing_left;

  // A zero velocity keeps the last facing. The committed copy changes only at
  // frame start so a sprite never flips halfway down the screen.
  always_ff @(posedge clock) begin
    if (reset) begin
      facing_left <= 1'b0;
      mirror      <= 1'b0;
    end else begin
      if (tick) begin
        if (vel_x < 13'sd0)      facing_left <= 1'b1;
        else if (vel_x > 13'sd0) facing_left <= 1'b0;
      end
      if (frame_start) mirror <= facing_left;
    end
  end
`else
  assign mirror = 1'b0;
`endif

  // Half-open hit test against the committed position. The offsets are
  // truncated to the texel field, so their values only matter when hit is set.
  always_comb begin
    in_x  = (display_col >= pos_x) &&
            ({1'b0, display_col} < ({1'b0, pos_x} + 13'(SIZE)));
    in_y  = (display_row >= pos_y) &&
            ({1'b0, display_row} < ({1'b0, pos_y} + 12'(SIZE)));
    hit   = in_x && in_y;
    tex_x = TEX_BITS'((display_col - pos_x) >> SCALE_LOG2);
    tex_y = TEX_BITS'((display_row - pos_y) >> SCALE_LOG2);
    if (mirror) tex_x = ~tex_x;
    addr_next = hit ? {tex_y, tex_x} : '0;
  end

  // The hit flag travels next to the ROM read, so the flag and the ROM data
  // line up. Reset clears both flag stages, so no stale pixel is emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr <= '0;
      hit_s0   <= 1'b0;
      hit_s1   <= 1'b0;
    end else begin
      rom_addr <= addr_next;
      hit_s0   <= hit;
      hit_s1   <= hit_s0;
    end
  end

  assign pixel_index  = hit_s1 ? rom_data : 4'd0;
  assign pixel_opaque = hit_s1 && (rom_data != 4'(TRANSPARENT));

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine
// -----------------------------------------------------------------------------
// Randomised scoreboard bench for sprite_engine, built with TICK_BITS = 4.
// The driver pushes the expected response of every cycle into two queues: the
// ROM address and position after the next edge, and the pixel two edges later.
// A separate monitor pops each entry when its edge has passed and compares it.
// -----------------------------------------------------------------------------
module tb_sprite_engine;

  localparam int HF    = 799;
  localparam int VF    = 599;
  localparam int SZ    = 64;
  localparam int SX    = 368;
  localparam int SY    = 268;
  localparam int TBITS = 4;
  localparam int DZ    = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] display_col = 12'd0;
  logic [10:0] display_row = 11'd0;
  logic [7:0]  joy_x = 8'h80;
  logic [7:0]  joy_y = 8'h80;
  logic        joy_valid = 1'b0;
  logic        edge_mode = 1'b0;
  logic [7:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [11:0] pos_x;
  logic [10:0] pos_y;
  logic [3:0]  pixel_index;
  logic        pixel_opaque;

  sprite_engine #(.TICK_BITS(TBITS)) dut (
    .clock(clock),
    .reset(reset),
    .display_col(display_col),
    .display_row(display_row),
    .joy_x(joy_x),
    .joy_y(joy_y),
    .joy_valid(joy_valid),
    .edge_mode(edge_mode),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .pixel_index(pixel_index),
    .pixel_opaque(pixel_opaque)
  );

  always #5 clock = ~clock;

  // Synchronous bitmap ROM with random contents; about a quarter of the
  // texels hold the transparent index.
  logic [3:0] rom_mem [256];
  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  typedef struct { int ready; int addr; int px; int py; } stage_t;
  typedef struct { int ready; int idx; bit opq; } pix_t;

  stage_t stage_q[$];
  pix_t   pix_q[$];

  int passed = 0;
  int total  = 0;
  int edges  = 0;

  // Behavioural model state.
  int         m_wx, m_wy, m_px, m_py, m_tcnt;
  logic [7:0] m_jx, m_jy;
  bit         m_dir, m_dirc;
  bit         m_valid = 1'b0;
  bit         cur_em = 1'b0;

  function automatic int velocity(int raw);
    if (raw >= -DZ && raw <= DZ) return 0;
    return raw;
  endfunction

  function automatic int move(int w, int v, int field, bit clamp);
    int n;
    n = w + v;
    if (clamp) begin
      if (n < 1) n = 1;
      if (n > field - SZ) n = field - SZ;
    end else begin
      if (n < 1) n = field - SZ - 1;
      if (n + SZ > field) n = 1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one cycle of inputs, predicts the response and advances the model
  // across the coming clock edge.
  task automatic applyStimulus(input bit rst, input int col, input int row,
                               input bit jv, input logic [7:0] jx,
                               input logic [7:0] jy, input bit em);
    int eaddr, eidx, dx, dy, vx, vy;
    bit eopq, hit, tick;
    @(negedge clock);
    reset       = rst;
    display_col = 12'(col);
    display_row = 11'(row);
    joy_valid   = jv;
    joy_x       = jx;
    joy_y       = jy;
    edge_mode   = em;

    hit = (col >= m_px) && (col < m_px + SZ) && (row >= m_py) && (row < m_py + SZ);
    dx = (col - m_px) / 4;
    dy = (row - m_py) / 4;
    if (m_dirc) dx = 15 - dx;
    eaddr = hit ? dy * 16 + dx : 0;
    eidx  = hit ? int'(rom_mem[eaddr]) : 0;
    eopq  = hit && (eidx != 0);
    if (rst) begin
      eaddr = 0;
      eidx  = 0;
      eopq  = 1'b0;
      foreach (pix_q[i]) begin
        if (pix_q[i].ready == edges + 1) begin
          pix_q[i].idx = 0;
          pix_q[i].opq = 1'b0;
        end
      end
    end
    if (rst || m_valid) pix_q.push_back('{edges + 2, eidx, eopq});

    if (rst) begin
      m_wx = SX; m_wy = SY; m_px = SX; m_py = SY; m_tcnt = 0;
      m_jx = 8'h80; m_jy = 8'h80; m_dir = 1'b0; m_dirc = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      tick   = (m_tcnt == (1 << TBITS) - 1);
      m_tcnt = (m_tcnt + 1) % (1 << TBITS);
      if (col == 0 && row == 0) begin
        m_px = m_wx; m_py = m_wy; m_dirc = m_dir;
      end
      if (tick) begin
        vx = velocity(int'(m_jx[7:4]) - 8);
        vy = velocity(8 - int'(m_jy[7:4]));
        m_wx = move(m_wx, vx, HF, em);
        m_wy = move(m_wy, vy, VF, em);
`ifdef SPRITE_MIRROR_EN
        if (vx < 0) m_dir = 1'b1;
        else if (vx > 0) m_dir = 1'b0;
`endif
      end
      if (jv) begin
        m_jx = jx; m_jy = jy;
      end
    end
    if (m_valid) stage_q.push_back('{edges + 1, eaddr, m_px, m_py});
  endtask

  task automatic step(input int col, input int row);
    applyStimulus(1'b0, col, row, 1'b0, 8'($urandom), 8'($urandom), cur_em);
  endtask

  task automatic strobe(input logic [7:0] jx, input logic [7:0] jy);
    applyStimulus(1'b0, 100, 100, 1'b1, jx, jy, cur_em);
  endtask

  function automatic int nearCol();
    int c;
    c = m_px - 8 + int'($urandom_range(0, 80));
    if (c < 0) c = 0;
    if (c > HF) c = HF;
    return c;
  endfunction

  function automatic int nearRow();
    int r;
    r = m_py - 8 + int'($urandom_range(0, 80));
    if (r < 0) r = 0;
    if (r > VF) r = VF;
    return r;
  endfunction

  task automatic runScan(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 24 == 0) step(0, 0);
      else step(nearCol(), nearRow());
    end
  endtask

  task automatic waitTickCycle();
    for (int k = 0; k < 16 && m_tcnt != (1 << TBITS) - 1; k++) step(nearCol(), nearRow());
  endtask

  // Monitor: compares every entry whose clock edge has just passed.
  initial begin
    stage_t s;
    pix_t   p;
    forever begin
      @(posedge clock);
      edges++;
      #1;
      while (stage_q.size() > 0 && stage_q[0].ready <= edges) begin
        s = stage_q.pop_front();
        checkOutput("rom_addr", 32'(rom_addr), 32'(s.addr));
        checkOutput("pos_x", 32'(pos_x), 32'(s.px));
        checkOutput("pos_y", 32'(pos_y), 32'(s.py));
      end
      while (pix_q.size() > 0 && pix_q[0].ready <= edges) begin
        p = pix_q.pop_front();
        checkOutput("pixel_index", 32'(pixel_index), 32'(p.idx));
        checkOutput("pixel_opaque", 32'(pixel_opaque), 32'(p.opq));
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));

    repeat (3) applyStimulus(1'b1, 5, 5, 1'b0, 8'h80, 8'h80, 1'b0);

    // Centred stick: the sprite stays at its start position.
    runScan(64);
    for (int c = 360; c <= 436; c++) step(c, 268);

    // Full right push, then a joystick strobe that lands on a tick.
    strobe(8'hF0, 8'h80);
    runScan(100);
    strobe(8'h80, 8'h80);
    runScan(20);
    waitTickCycle();
    applyStimulus(1'b0, 100, 100, 1'b1, 8'hF0, 8'h80, cur_em);
    runScan(40);

    // Frame commit that coincides with a tick.
    waitTickCycle();
    step(0, 0);
    runScan(20);

    // Edge handling: clamp at the left/bottom, wrap, clamp at the right/top, wrap.
    cur_em = 1'b1;
    strobe(8'h00, 8'h00);
    runScan(960);
    cur_em = 1'b0;
    runScan(48);
    cur_em = 1'b1;
    strobe(8'hF0, 8'hF0);
    runScan(1920);
    cur_em = 1'b0;
    runScan(80);

    // Slow leftward travel, then reset while scanning inside the sprite.
    strobe(8'h50, 8'h80);
    runScan(64);
    step(0, 0);
    step(m_px, m_py);
    step(m_px + 1, m_py + 1);
    applyStimulus(1'b1, m_px + 2, m_py + 2, 1'b0, 8'h80, 8'h80, cur_em);
    runScan(30);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if ($urandom_range(0, 99) < 3) cur_em = ~cur_em;
      if (r < 2) applyStimulus(1'b1, nearCol(), nearRow(), 1'b0, 8'h80, 8'h80, cur_em);
      else if (r < 80) applyStimulus(1'b0, nearCol(), nearRow(), 1'b1,
                                     8'($urandom), 8'($urandom), cur_em);
      else if (r < 120) step(0, 0);
      else if (r < 350) step(int'($urandom_range(0, HF)), int'($urandom_range(0, VF)));
      else step(nearCol(), nearRow());
    end

    repeat (4) step(700, 500);
    repeat (3) @(negedge clock);
    checkOutput("stage_queue_drained", 32'(stage_q.size()), 32'd0);
    checkOutput("pixel_queue_drained", 32'(pix_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
